uart_rx_cmd_ctrl: RTL and testbench



---
 rtl/uart_rx_cmd_ctrl_pkg.sv | 29 ++
 rtl/uart_rx_cmd_ctrl_frame_timeout.sv | 29 ++
 rtl/uart_rx_cmd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared definitions for the UART receive-side command controller:
// opcodes, FSM state encoding and ALU operand register addresses.
package uart_rx_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [7:0] ALU_A_ADDR = 8'h00;
  localparam logic [7:0] ALU_B_ADDR = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT
  } state_e;

  // States during which the ALU clock must run.
  function automatic logic is_alu_state(input state_e s);
    return (s == ALU_A) || (s == ALU_B) || (s == ALU_FUN) || (s == ALU_WAIT);
  endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_frame_timeout.sv
// Inter-byte timeout: counts cycles while a frame is open and pulses expire
// in the cycle the count reaches TOUT_CYC-1 (TOUT_CYC must be at least 2).
module frame_timeout #(
  parameter int unsigned TOUT_W   = 16,
  parameter int unsigned TOUT_CYC = 16'hFFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [TOUT_W-1:0] cnt;

  // expire is registered one count early so it coincides with cnt == TOUT_CYC-1.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (run) begin
      cnt    <= cnt + TOUT_W'(1);
      expire <= (cnt == TOUT_W'(TOUT_CYC - 2));
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Command controller behind the UART receiver: parses received bytes into
// register-file writes/reads and ALU starts, aborting bad or stalled frames.
module uart_rx_cmd_ctrl
  import uart_rx_cmd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned TOUT_W   = 16,
  parameter int unsigned TOUT_CYC = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_par_err,
  input  logic              rx_frm_err,
  input  logic              alu_out_valid,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_wr_data,
  output logic              alu_en,
  output logic [3:0]        alu_fun,
  output logic              clk_gate_en,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rf_wr_en_d, rf_rd_en_d, alu_en_d, frame_err_d;
  logic [ADDR_W-1:0] rf_addr_d;
  logic [7:0]        rf_wr_data_d;
  logic [3:0]        alu_fun_d;
  logic              byte_bad;
  logic              tout_clear, tout_run, tout_expire;

  assign byte_bad   = rx_valid && (rx_par_err || rx_frm_err);
  assign tout_clear = rx_valid || (state_d != state_q);
  assign tout_run   = (state_q != IDLE);

  frame_timeout #(
    .TOUT_W   (TOUT_W),
    .TOUT_CYC (TOUT_CYC)
  ) u_frame_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tout_clear),
    .run    (tout_run),
    .expire (tout_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rf_wr_en    <= rf_wr_en_d;
      rf_rd_en    <= rf_rd_en_d;
      rf_addr     <= rf_addr_d;
      rf_wr_data  <= rf_wr_data_d;
      alu_en      <= alu_en_d;
      alu_fun     <= alu_fun_d;
      clk_gate_en <= is_alu_state(state_d) || alu_en_d;
      busy        <= (state_d != IDLE);
      frame_err   <= frame_err_d;
      if (frame_err_d && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Next state and strobes; precedence: ALU answer, error byte, good byte, timeout.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr;
    rf_wr_data_d = rf_wr_data;
    alu_en_d     = 1'b0;
    alu_fun_d    = alu_fun;
    frame_err_d  = 1'b0;

    if ((state_q == ALU_WAIT) && alu_out_valid) begin
      state_d     = IDLE;
      frame_err_d = rx_valid;
    end else if (byte_bad) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == CMD_RF_WR) begin
            state_d = WR_ADDR;
          end else if (rx_data == CMD_RF_RD) begin
            state_d = RD_ADDR;
          end else if (rx_data == CMD_ALU_OP) begin
            state_d = ALU_A;
          end else if (rx_data == CMD_ALU_NOP) begin
            state_d = ALU_FUN;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        WR_ADDR: begin
          wr_addr_d = rx_data[ADDR_W-1:0];
          state_d   = WR_DATA;
        end
        WR_DATA: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = wr_addr_q;
          rf_wr_data_d = rx_data;
          state_d      = IDLE;
        end
        RD_ADDR: begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rx_data[ADDR_W-1:0];
          state_d    = IDLE;
        end
        ALU_A: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_W'(ALU_A_ADDR);
          rf_wr_data_d = rx_data;
          state_d      = ALU_B;
        end
        ALU_B: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_W'(ALU_B_ADDR);
          rf_wr_data_d = rx_data;
          state_d      = ALU_FUN;
        end
        ALU_FUN: begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_data[3:0];
          state_d   = ALU_WAIT;
        end
        ALU_WAIT: begin
          frame_err_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (tout_expire) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl with a short timeout (TOUT_CYC = 8).
module tb_uart_rx_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_par_err;
  logic       rx_frm_err;
  logic       alu_out_valid;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       clk_gate_en;
  logic       busy;
  logic       frame_err;
  logic [7:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;
  int wr_pulses = 0;
  logic [7:0] exp_err = 8'd0;

  uart_rx_cmd_ctrl #(
    .ADDR_W   (4),
    .TOUT_W   (16),
    .TOUT_CYC (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_par_err    (rx_par_err),
    .rx_frm_err    (rx_frm_err),
    .alu_out_valid (alu_out_valid),
    .rf_wr_en      (rf_wr_en),
    .rf_rd_en      (rf_rd_en),
    .rf_addr       (rf_addr),
    .rf_wr_data    (rf_wr_data),
    .alu_en        (alu_en),
    .alu_fun       (alu_fun),
    .clk_gate_en   (clk_gate_en),
    .busy          (busy),
    .frame_err     (frame_err),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rf_wr_en === 1'b1) wr_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pe = 1'b0, input logic fe = 1'b0);
    rx_valid = 1'b1; rx_data = b; rx_par_err = pe; rx_frm_err = fe;
    tick();
    rx_valid = 1'b0; rx_par_err = 1'b0; rx_frm_err = 1'b0;
  endtask

  task automatic alu_answer();
    alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    vectors++; if ({rf_wr_en, rf_rd_en, alu_en, clk_gate_en, busy, frame_err} !== 6'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b exp 000000", {rf_wr_en, rf_rd_en, alu_en, clk_gate_en, busy, frame_err}); end
    vectors++; if ({rf_addr, rf_wr_data, alu_fun, err_cnt} !== 24'h0) begin
      miscompares++; $display("FAIL reset_data: got %h exp 000000", {rf_addr, rf_wr_data, alu_fun, err_cnt}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int base;
    base = wr_pulses;
    send_byte(8'hAA);
    send_byte(8'h05);
    vectors++; if (rf_wr_en !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL write_mid: got wr=%b busy=%b exp wr=0 busy=1", rf_wr_en, busy); end
    send_byte(8'h3C);
    vectors++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
      miscompares++; $display("FAIL write_strobe: got wr=%b addr=%h data=%h exp wr=1 addr=5 data=3c", rf_wr_en, rf_addr, rf_wr_data); end
    tick();
    vectors++; if (rf_wr_en !== 1'b0 || busy !== 1'b0 || wr_pulses != base + 1) begin
      miscompares++; $display("FAIL write_once: got wr=%b busy=%b pulses=%0d exp wr=0 busy=0 pulses=%0d", rf_wr_en, busy, wr_pulses - base, 1); end
  endtask

  task automatic test_read_opcode_err();
    send_byte(8'hBB);
    send_byte(8'h0A);
    vectors++; if (rf_rd_en !== 1'b1 || rf_addr !== 4'hA || rf_wr_en !== 1'b0) begin
      miscompares++; $display("FAIL read_strobe: got rd=%b addr=%h wr=%b exp rd=1 addr=a wr=0", rf_rd_en, rf_addr, rf_wr_en); end
    send_byte(8'h77);
    exp_err = exp_err + 8'd1;
    vectors++; if (frame_err !== 1'b1 || err_cnt !== exp_err || busy !== 1'b0 || rf_rd_en !== 1'b0) begin
      miscompares++; $display("FAIL bad_opcode: got ferr=%b cnt=%0d busy=%b rd=%b exp ferr=1 cnt=%0d busy=0 rd=0", frame_err, err_cnt, busy, rf_rd_en, exp_err); end
    tick();
    vectors++; if (frame_err !== 1'b0) begin
      miscompares++; $display("FAIL ferr_pulse: got %b exp 0", frame_err); end
  endtask

  task automatic test_alu_operands();
    send_byte(8'hCC);
    vectors++; if (clk_gate_en !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL alu_gate_on: got gate=%b busy=%b exp 1 1", clk_gate_en, busy); end
    send_byte(8'h12);
    vectors++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'h0 || rf_wr_data !== 8'h12) begin
      miscompares++; $display("FAIL alu_op_a: got wr=%b addr=%h data=%h exp 1 0 12", rf_wr_en, rf_addr, rf_wr_data); end
    send_byte(8'h34);
    vectors++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'h1 || rf_wr_data !== 8'h34) begin
      miscompares++; $display("FAIL alu_op_b: got wr=%b addr=%h data=%h exp 1 1 34", rf_wr_en, rf_addr, rf_wr_data); end
    send_byte(8'h01);
    vectors++; if (alu_en !== 1'b1 || alu_fun !== 4'h1 || clk_gate_en !== 1'b1 || rf_wr_en !== 1'b0) begin
      miscompares++; $display("FAIL alu_start: got en=%b fun=%h gate=%b wr=%b exp 1 1 1 0", alu_en, alu_fun, clk_gate_en, rf_wr_en); end
    repeat (3) tick();
    vectors++; if (alu_en !== 1'b0 || clk_gate_en !== 1'b1 || busy !== 1'b1 || alu_fun !== 4'h1) begin
      miscompares++; $display("FAIL alu_wait: got en=%b gate=%b busy=%b fun=%h exp 0 1 1 1", alu_en, clk_gate_en, busy, alu_fun); end
    alu_answer();
    vectors++; if (busy !== 1'b0 || clk_gate_en !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++; $display("FAIL alu_done: got busy=%b gate=%b ferr=%b exp 0 0 0", busy, clk_gate_en, frame_err); end
  endtask

  task automatic test_parity_err();
    int base;
    base = wr_pulses;
    send_byte(8'hAA);
    send_byte(8'h05, 1'b1, 1'b0);
    exp_err = exp_err + 8'd1;
    vectors++; if (frame_err !== 1'b1 || rf_wr_en !== 1'b0 || busy !== 1'b0 || err_cnt !== exp_err) begin
      miscompares++; $display("FAIL par_err: got ferr=%b wr=%b busy=%b cnt=%0d exp 1 0 0 %0d", frame_err, rf_wr_en, busy, err_cnt, exp_err); end
    send_byte(8'hDD);
    vectors++; if (busy !== 1'b1 || clk_gate_en !== 1'b1 || frame_err !== 1'b0) begin
      miscompares++; $display("FAIL nop_open: got busy=%b gate=%b ferr=%b exp 1 1 0", busy, clk_gate_en, frame_err); end
    send_byte(8'h02);
    vectors++; if (alu_en !== 1'b1 || alu_fun !== 4'h2 || wr_pulses != base) begin
      miscompares++; $display("FAIL nop_start: got en=%b fun=%h wrs=%0d exp 1 2 0", alu_en, alu_fun, wr_pulses - base); end
    alu_answer();
    // framing error in an open frame behaves the same; upper fun bits are dropped
    send_byte(8'hBB);
    send_byte(8'h03, 1'b0, 1'b1);
    exp_err = exp_err + 8'd1;
    vectors++; if (frame_err !== 1'b1 || rf_rd_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL frm_err: got ferr=%b rd=%b busy=%b exp 1 0 0", frame_err, rf_rd_en, busy); end
    send_byte(8'hDD);
    send_byte(8'hF7);
    vectors++; if (alu_en !== 1'b1 || alu_fun !== 4'h7) begin
      miscompares++; $display("FAIL fun_mask: got en=%b fun=%h exp 1 7", alu_en, alu_fun); end
    alu_answer();
  endtask

  task automatic test_timeout();
    send_byte(8'hAA);
    for (int i = 1; i <= 7; i++) begin
      tick();
      vectors++; if (frame_err !== 1'b0 || busy !== 1'b1) begin
        miscompares++; $display("FAIL tout_early_%0d: got ferr=%b busy=%b exp 0 1", i, frame_err, busy); end
    end
    tick();
    exp_err = exp_err + 8'd1;
    vectors++; if (frame_err !== 1'b1 || busy !== 1'b0 || err_cnt !== exp_err) begin
      miscompares++; $display("FAIL tout_abort: got ferr=%b busy=%b cnt=%0d exp 1 0 %0d", frame_err, busy, err_cnt, exp_err); end
    send_byte(8'hAA);
    repeat (7) tick();
    send_byte(8'h05);
    vectors++; if (frame_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL tout_rescue: got ferr=%b busy=%b exp 0 1", frame_err, busy); end
    send_byte(8'h3C);
    vectors++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'h5 || rf_wr_data !== 8'h3C || err_cnt !== exp_err) begin
      miscompares++; $display("FAIL tout_write: got wr=%b addr=%h data=%h cnt=%0d exp 1 5 3c %0d", rf_wr_en, rf_addr, rf_wr_data, err_cnt, exp_err); end
    // silent ALU is also aborted by the timeout
    send_byte(8'hDD);
    send_byte(8'h04);
    repeat (7) tick();
    vectors++; if (frame_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL tout_alu_early: got ferr=%b busy=%b exp 0 1", frame_err, busy); end
    tick();
    exp_err = exp_err + 8'd1;
    vectors++; if (frame_err !== 1'b1 || busy !== 1'b0 || clk_gate_en !== 1'b0) begin
      miscompares++; $display("FAIL tout_alu: got ferr=%b busy=%b gate=%b exp 1 0 0", frame_err, busy, clk_gate_en); end
  endtask

  task automatic test_alu_wait_bytes();
    send_byte(8'hDD);
    send_byte(8'h03);
    send_byte(8'h55);
    exp_err = exp_err + 8'd1;
    vectors++; if (frame_err !== 1'b1 || busy !== 1'b1 || clk_gate_en !== 1'b1) begin
      miscompares++; $display("FAIL wait_discard: got ferr=%b busy=%b gate=%b exp 1 1 1", frame_err, busy, clk_gate_en); end
    alu_out_valid = 1'b1;
    send_byte(8'hAA);
    alu_out_valid = 1'b0;
    exp_err = exp_err + 8'd1;
    vectors++; if (frame_err !== 1'b1 || busy !== 1'b0 || err_cnt !== exp_err) begin
      miscompares++; $display("FAIL wait_collide: got ferr=%b busy=%b cnt=%0d exp 1 0 %0d", frame_err, busy, err_cnt, exp_err); end
    alu_answer();
    vectors++; if (frame_err !== 1'b0 || busy !== 1'b0 || alu_en !== 1'b0) begin
      miscompares++; $display("FAIL idle_aluv: got ferr=%b busy=%b en=%b exp 0 0 0", frame_err, busy, alu_en); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h11);
    vectors++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'h1 || rf_wr_data !== 8'h11) begin
      miscompares++; $display("FAIL b2b_write: got wr=%b addr=%h data=%h exp 1 1 11", rf_wr_en, rf_addr, rf_wr_data); end
    send_byte(8'hBB);
    vectors++; if (rf_wr_en !== 1'b0 || rf_addr !== 4'h1 || rf_wr_data !== 8'h11) begin
      miscompares++; $display("FAIL b2b_hold: got wr=%b addr=%h data=%h exp 0 1 11", rf_wr_en, rf_addr, rf_wr_data); end
    send_byte(8'h02);
    vectors++; if (rf_rd_en !== 1'b1 || rf_addr !== 4'h2 || rf_wr_data !== 8'h11 || err_cnt !== exp_err) begin
      miscompares++; $display("FAIL b2b_read: got rd=%b addr=%h data=%h cnt=%0d exp 1 2 11 %0d", rf_rd_en, rf_addr, rf_wr_data, err_cnt, exp_err); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = wr_pulses;
    send_byte(8'hAA);
    send_byte(8'h05);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err = 8'd0;
    vectors++; if (rf_wr_en !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'h00) begin
      miscompares++; $display("FAIL reset_mid: got wr=%b ferr=%b busy=%b cnt=%0d exp 0 0 0 0", rf_wr_en, frame_err, busy, err_cnt); end
    repeat (10) tick();
    vectors++; if (frame_err !== 1'b0 || err_cnt !== 8'h00 || wr_pulses != base) begin
      miscompares++; $display("FAIL reset_quiet: got ferr=%b cnt=%0d wrs=%0d exp 0 0 0", frame_err, err_cnt, wr_pulses - base); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 260; i++) begin
      send_byte(8'h77);
      if (i == 254 || i == 255 || i == 260) begin
        exp_err = (i >= 255) ? 8'hFF : 8'(i);
        vectors++; if (err_cnt !== exp_err || frame_err !== 1'b1) begin
          miscompares++; $display("FAIL sat_%0d: got cnt=%0d ferr=%b exp %0d 1", i, err_cnt, frame_err, exp_err); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    rx_par_err = 1'b0; rx_frm_err = 1'b0; alu_out_valid = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read_opcode_err();
    test_alu_operands();
    test_parity_err();
    test_timeout();
    test_alu_wait_bytes();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run by 200000 exp earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
